ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 16x8 synchronous RAM (we/oe/address/data_in/data_out).
- Port A is the CPU memory path; port B is the program loader/debug path.
- Grants one request at a time, round-robin on contention, and generates RAM write and read timing.
- Returns a one-cycle done pulse per completed request; read data is held on a shared rdata bus.

Parameters:
ADDR_WIDTH, 4, RAM address width (16 words)
DATA_WIDTH, 8, RAM data width

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
req_a  input  1  port A request; hold until done_a
we_a  input  1  port A: 1=write, 0=read; hold with req_a
addr_a  input  ADDR_WIDTH  port A address; hold with req_a
wdata_a  input  DATA_WIDTH  port A write data; hold with req_a
req_b, we_b, addr_b, wdata_b  input  1/1/ADDR_WIDTH/DATA_WIDTH  port B equivalents
done_a  output  1  one-cycle pulse: port A request complete
done_b  output  1  one-cycle pulse: port B request complete
gnt_a  output  1  high while port A owns the RAM (state != IDLE)
gnt_b  output  1  high while port B owns the RAM
rdata  output  DATA_WIDTH  captured read data; valid with done_x of a read; held until next read capture
ram_we  output  1  to RAM we
ram_oe  output  1  to RAM oe
ram_address  output  ADDR_WIDTH  to RAM address
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_data_out  input  DATA_WIDTH  from RAM data_out

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset.
- All outputs are registered.
- Reset values:
  - state=IDLE.
  - ram_we=0, ram_oe=0, ram_address=0, ram_data_in=0.
  - rdata=0, done_a=done_b=0, gnt_a=gnt_b=0.
  - last_grant=B, so A wins the first tie.
- States: IDLE, WR, RD1, RD2, DONE.
- Request sampling:
  - req_x is sampled only in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to last_grant wins, then last_grant is updated.
  - On the winning edge, ram_address and ram_data_in are latched from the winner.
- IDLE transitions:
  - IDLE -> WR if we=1, with ram_we=1.
  - IDLE -> RD1 if we=0, with ram_oe=1.
  - gnt_x is set on the winning edge.
- Write path:
  - WR lasts exactly 1 cycle with ram_we=1; the RAM writes on the edge that ends WR.
  - WR -> DONE, with ram_we=0.
- Read path:
  - RD1 lasts 1 cycle with ram_oe=1; the RAM registers the read.
  - RD1 -> RD2, with ram_oe still 1.
  - At the edge leaving RD2, rdata <= ram_data_out.
  - RD2 -> DONE, with ram_oe=0.
- DONE:
  - done_x=1 for exactly one cycle.
  - DONE -> IDLE; gnt_x and done_x clear on that edge.
- Latency (request seen at edge E0):
  - Write: done high between E1 and E2.
  - Read: done and rdata valid between E2 and E3.
  - Minimum spacing between back-to-back grants: write 3 cycles, read 4 cycles.
- Requester obligations:
  - Hold req, we, addr and wdata stable until done.
  - Deassert req before the first IDLE edge after done; a req still high there is a new request.
- No preemption: a request arriving mid-transaction waits; the loser's req stays pending and is granted at the next IDLE.
- ram_address and ram_data_in hold their last values in IDLE; ram_we and ram_oe are never both 1.
- Reset mid-operation:
  - Next edge gives state=IDLE with all outputs at reset values; no done is issued.
  - A write whose WR cycle coincides with the reset edge may still land in the RAM.
- Address and data are passed through unmodified; no wrap logic is required.

Test Plan:
- Single write then read, port A: write 0xAB to addr 0x3 → done_a one cycle at E1, ram_we high exactly 1 cycle. Then read addr 0x3 → done_a at E2, rdata=0xAB.
- Port B, write 0xCD to 0xA then read 0xA: rdata=0xCD with done_b. Port A idle throughout: gnt_a=0, done_a=0.
- Simultaneous reads from reset (A→0x3, B→0xA): A granted first, rdata=0xAB with done_a. Then B granted at the next IDLE, rdata=0xCD with done_b. Both held continuously → grants alternate A,B,A,B.
- Contention during a busy transaction: B requests while A's read is in RD1 → gnt_b stays 0 until A's DONE completes. B is then granted with no lost request and the correct data returned.
- Reset asserted during RD2 → next cycle state IDLE, ram_oe=0, gnt_a=0, rdata=0, no done pulse. A fresh request after reset is serviced normally.
- Invariant checks every cycle:
  - ram_we & ram_oe == 0.
  - gnt_a & gnt_b == 0.
  - done pulses are one cycle wide.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and sequencer for a shared 16x8 synchronous RAM
//
// Purpose:
//    Grants one of two requesters (A = CPU path, B = loader/debug path) access to a
//    shared synchronous RAM, one request at a time, round-robin on contention.
//    Sequences the RAM write (one we cycle) and read (two oe-related cycles) timing
//    and returns a one-cycle done pulse per completed request.
//
// Ports:
//    clk            system clock, all logic on posedge
//    reset          synchronous, active-high
//    req_a/b        request, held until done_a/b
//    we_a/b         1 = write, 0 = read, held with req
//    addr_a/b       word address, held with req
//    wdata_a/b      write data, held with req
//    done_a/b       one-cycle completion pulse
//    gnt_a/b        high while that port owns the RAM
//    rdata          captured read data, valid with done of a read, held until next read
//    ram_we         RAM write enable
//    ram_oe         RAM read enable
//    ram_address    RAM address
//    ram_data_in    RAM write data
//    ram_data_out   RAM registered read data

module ram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic                  req_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  done_a,
   output logic                  done_b,
   output logic                  gnt_a,
   output logic                  gnt_b,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD1  = 3'd2,
      RD2  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state;
   logic   last_grant_b;   // 1 when B received the most recent grant
   logic   owner_b;        // port that owns the current transaction
   logic   pick_b;

   // B wins when it is the only requester, or on a tie when A was served last.
   always_comb begin
      pick_b = req_b && (!req_a || !last_grant_b);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant_b <= 1'b1;
         owner_b      <= 1'b0;
         done_a       <= 1'b0;
         done_b       <= 1'b0;
         gnt_a        <= 1'b0;
         gnt_b        <= 1'b0;
         rdata        <= '0;
         ram_we       <= 1'b0;
         ram_oe       <= 1'b0;
         ram_address  <= '0;
         ram_data_in  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  owner_b      <= pick_b;
                  last_grant_b <= pick_b;
                  gnt_a        <= !pick_b;
                  gnt_b        <= pick_b;
                  ram_address  <= pick_b ? addr_b  : addr_a;
                  ram_data_in  <= pick_b ? wdata_b : wdata_a;
                  if (pick_b ? we_b : we_a) begin
                     ram_we <= 1'b1;
                     state  <= WR;
                  end else begin
                     ram_oe <= 1'b1;
                     state  <= RD1;
                  end
               end
            end
            WR: begin
               // RAM commits the write on this edge.
               ram_we <= 1'b0;
               done_a <= !owner_b;
               done_b <= owner_b;
               state  <= DONE;
            end
            RD1: begin
               // RAM registers the read word on this edge; oe stays up one more cycle.
               state <= RD2;
            end
            RD2: begin
               rdata  <= ram_data_out;
               ram_oe <= 1'b0;
               done_a <= !owner_b;
               done_b <= owner_b;
               state  <= DONE;
            end
            DONE: begin
               done_a <= 1'b0;
               done_b <= 1'b0;
               gnt_a  <= 1'b0;
               gnt_b  <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural 16x8 RAM
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a, we_a, req_b, we_b;
   logic [3:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       done_a, done_b, gnt_a, gnt_b;
   logic [7:0] rdata;
   logic       ram_we, ram_oe;
   logic [3:0] ram_address;
   logic [7:0] ram_data_in;
   logic [7:0] ram_data_out = 8'h00;
   logic [7:0] mem [16];

   int errors = 0;
   int checks = 0;
   bit inv_en = 1'b0;
   logic prev_done_a = 1'b0, prev_done_b = 1'b0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .done_a(done_a), .done_b(done_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
      .rdata(rdata), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out)
   );

   // Behavioural synchronous RAM: write on we, registered read on oe.
   always @(posedge clk) begin
      if (ram_we) mem[ram_address] <= ram_data_in;
      if (ram_oe) ram_data_out <= mem[ram_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (inv_en) begin
         chk("inv_we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
         chk("inv_gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
         chk("inv_done_a_width", 32'(done_a & prev_done_a), 32'd0);
         chk("inv_done_b_width", 32'(done_b & prev_done_b), 32'd0);
      end
      prev_done_a = done_a;
      prev_done_b = done_b;
   end

   typedef struct {
      bit         port_b;
      bit         we;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         exp_lat;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[8];

   // Single-port transaction, issued #1 after a posedge; latency counts edges to done.
   task automatic do_txn(input int id, input vec_t v);
      int cyc = 0, lat = 0, we_cnt = 0, oe_cnt = 0;
      logic other = 1'b0;
      logic [7:0] rd = 8'h00;
      bit seen = 0;
      if (v.port_b) begin
         req_b = 1'b1; we_b = v.we; addr_b = v.addr; wdata_b = v.wdata;
      end else begin
         req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
      end
      while (!seen && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (ram_we) we_cnt++;
         if (ram_oe) oe_cnt++;
         if (cyc == 1) begin
            chk($sformatf("v%0d_grant", id), 32'(v.port_b ? gnt_b : gnt_a), 32'd1);
            chk($sformatf("v%0d_address", id), 32'(ram_address), 32'(v.addr));
            if (v.we) chk($sformatf("v%0d_data_in", id), 32'(ram_data_in), 32'(v.wdata));
         end
         other = other | (v.port_b ? (gnt_a | done_a) : (gnt_b | done_b));
         if (v.port_b ? done_b : done_a) begin
            seen = 1; lat = cyc; rd = rdata;
            if (v.port_b) req_b = 1'b0; else req_a = 1'b0;
         end
      end
      if (!seen) begin
         req_a = 1'b0; req_b = 1'b0;
      end
      chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.exp_lat));
      if (!v.we) chk($sformatf("v%0d_rdata", id), 32'(rd), 32'(v.exp_rd));
      chk($sformatf("v%0d_we_cycles", id), 32'(we_cnt), v.we ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_oe_cycles", id), 32'(oe_cnt), v.we ? 32'd0 : 32'd2);
      chk($sformatf("v%0d_other_port_quiet", id), 32'(other), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_release", id), 32'({done_a, done_b, gnt_a, gnt_b}), 32'd0);
   endtask

   // Two reads: A now, B after b_delay edges. Records completion and first-grant cycles.
   task automatic pair_run(input int b_delay, output int da, output int db, output int gb,
                           output logic [7:0] rda, output logic [7:0] rdb);
      int cyc = 0;
      da = 0; db = 0; gb = 0; rda = 8'h00; rdb = 8'h00;
      req_a = 1'b1; we_a = 1'b0; addr_a = 4'h3;
      we_b = 1'b0; addr_b = 4'hA;
      if (b_delay == 0) req_b = 1'b1;
      while ((da == 0 || db == 0) && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == b_delay) req_b = 1'b1;
         if (gnt_b && gb == 0) gb = cyc;
         if (done_a) begin da = cyc; rda = rdata; req_a = 1'b0; end
         if (done_b) begin db = cyc; rdb = rdata; req_b = 1'b0; end
      end
      req_a = 1'b0; req_b = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int da, db, gb, cyc, nd;
      logic [7:0] rda, rdb;
      int order [4];

      vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hAB, 2, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 3, 8'hAB};
      vecs[2] = '{1'b1, 1'b1, 4'hA, 8'hCD, 2, 8'h00};
      vecs[3] = '{1'b1, 1'b0, 4'hA, 8'h00, 3, 8'hCD};
      vecs[4] = '{1'b0, 1'b1, 4'hF, 8'h5A, 2, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 4'hF, 8'h00, 3, 8'h5A};
      vecs[6] = '{1'b1, 1'b1, 4'h0, 8'hFF, 2, 8'h00};
      vecs[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 3, 8'hFF};

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      reset = 1'b1;
      req_a = 1'b0; we_a = 1'b0; addr_a = 4'h0; wdata_a = 8'h00;
      req_b = 1'b0; we_b = 1'b0; addr_b = 4'h0; wdata_b = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_outputs", 32'({done_a, done_b, gnt_a, gnt_b, ram_we, ram_oe}), 32'd0);
      chk("reset_address", 32'(ram_address), 32'd0);
      chk("reset_data_in", 32'(ram_data_in), 32'd0);
      chk("reset_rdata", 32'(rdata), 32'd0);
      reset = 1'b0;
      inv_en = 1'b1;

      for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

      // Simultaneous reads from reset: A first (last_grant resets to B), B at next IDLE.
      do_reset();
      pair_run(0, da, db, gb, rda, rdb);
      chk("sim_done_a_cycle", 32'(da), 32'd3);
      chk("sim_rdata_a", 32'(rda), 32'hAB);
      chk("sim_gnt_b_cycle", 32'(gb), 32'd5);
      chk("sim_done_b_cycle", 32'(db), 32'd7);
      chk("sim_rdata_b", 32'(rdb), 32'hCD);

      // B arrives while A is in RD1: no preemption, B served right after.
      pair_run(1, da, db, gb, rda, rdb);
      chk("busy_done_a_cycle", 32'(da), 32'd3);
      chk("busy_rdata_a", 32'(rda), 32'hAB);
      chk("busy_gnt_b_cycle", 32'(gb), 32'd5);
      chk("busy_done_b_cycle", 32'(db), 32'd7);
      chk("busy_rdata_b", 32'(rdb), 32'hCD);

      // Both held: grants alternate A,B,A,B at 4-cycle read spacing.
      req_a = 1'b1; we_a = 1'b0; addr_a = 4'h3;
      req_b = 1'b1; we_b = 1'b0; addr_b = 4'hA;
      cyc = 0; nd = 0;
      while (nd < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done_a || done_b) begin
            order[nd] = done_b ? 1 : 0;
            chk($sformatf("alt_done%0d_cycle", nd), 32'(cyc), 32'(3 + 4 * nd));
            chk($sformatf("alt_done%0d_rdata", nd), 32'(rdata), done_b ? 32'hCD : 32'hAB);
            nd++;
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      chk("alt_count", 32'(nd), 32'd4);
      for (int i = 0; i < nd; i++) chk($sformatf("alt_order%0d", i), 32'(order[i]), 32'(i % 2));
      @(posedge clk); #1;

      // Reset during RD2 of a port A read.
      req_a = 1'b1; we_a = 1'b0; addr_a = 4'h3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid_in_rd2_oe", 32'(ram_oe), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      req_a = 1'b0;
      chk("rst_mid_gnt_a", 32'(gnt_a), 32'd0);
      chk("rst_mid_oe", 32'(ram_oe), 32'd0);
      chk("rst_mid_rdata", 32'(rdata), 32'd0);
      chk("rst_mid_done_a", 32'(done_a), 32'd0);
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done_a || done_b) nd++;
      end
      chk("rst_mid_no_late_done", 32'(nd), 32'd0);
      do_txn(8, vecs[3]);
      do_txn(9, vecs[1]);

      inv_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
